// File: rtl/elpis_uart_tx.sv
// elpis_uart_tx - buffered 8N1 UART transmitter for the Elpis user project.
//
// Bytes written by the core's output path are queued in a small circular
// FIFO and shifted out LSB first as start bit, eight data bits and a stop
// bit. Every bit lasts P = max(div_i, 2) clock cycles, with P latched at
// the start of each frame. Back-to-back frames have no idle gap between
// them. All logic runs on the rising edge of wb_clk_i.
//
// Ports
//   wb_clk_i    clock
//   wb_rst_i    synchronous active-high reset
//   div_i       clock cycles per bit, sampled at frame start (0/1 -> 2)
//   wr_en_i     push wr_data_i into the FIFO this cycle
//   wr_data_i   byte to transmit
//   clr_ovf_i   clears overflow_o
//   tx_o        serial line, idle high (registered)
//   tx_oeb_o    pad output enable, active-low, tied to 0
//   busy_o      frame in progress or FIFO non-empty
//   full_o      FIFO holds FIFO_DEPTH bytes (registered)
//   empty_o     FIFO holds no bytes (registered)
//   level_o     FIFO occupancy (registered)
//   overflow_o  sticky flag: a write was dropped (registered)

module elpis_uart_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [DIV_WIDTH-1:0]          div_i,
  input  logic                          wr_en_i,
  input  logic [7:0]                    wr_data_i,
  input  logic                          clr_ovf_i,
  output logic                          tx_o,
  output logic                          tx_oeb_o,
  output logic                          busy_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [LW-1:0]        r_level;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_ovf;

  // Serialiser state
  logic [1:0]           r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_period;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_tx;

  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic                 w_cnt_zero;
  logic [DIV_WIDTH-1:0] w_period;
  logic [7:0]           w_head;
  logic [LW-1:0]        w_level_nxt;

  assign w_push     = wr_en_i & ~r_full;
  // A write against a full FIFO is dropped even if a pop frees a slot in
  // the same cycle; full is the registered view the writer saw.
  assign w_drop     = wr_en_i & r_full;
  assign w_cnt_zero = (r_cnt == {DIV_WIDTH{1'b0}});
  assign w_period   = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_i;
  assign w_head     = r_mem[r_rptr];

  // Pop request: a new frame starts from IDLE, or straight after the last
  // stop-bit cycle so consecutive frames are contiguous.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = ~r_empty;
      ST_STOP: w_pop = w_cnt_zero & ~r_empty;
      default: w_pop = 1'b0;
    endcase
  end

  // Next FIFO occupancy from the accepted push and the pop
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LW'(1);
    end else begin
      w_level_nxt = r_level;
    end
  end

  // FIFO storage write port (contents need no reset; level gates reads)
  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data_i;
    end
  end

  // FIFO pointers, level and registered full/empty flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_level <= {LW{1'b0}};
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(FIFO_DEPTH));
      r_empty <= (w_level_nxt == {LW{1'b0}});
    end
  end

  // Sticky overflow flag; a dropped write beats a simultaneous clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf_i) begin
      r_ovf <= 1'b0;
    end
  end

  // Frame serialiser: the counter runs P-1 down to 0 for each bit, so
  // every bit, including start and stop, occupies exactly P cycles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {DIV_WIDTH{1'b0}};
      r_period  <= {DIV_WIDTH{1'b0}};
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift  <= w_head;
            r_period <= w_period;
            r_cnt    <= w_period - DIV_WIDTH'(1);
            r_tx     <= 1'b0;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          if (w_cnt_zero) begin
            r_state   <= ST_DATA;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_cnt     <= r_period - DIV_WIDTH'(1);
          end else begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
          end
        end
        ST_DATA: begin
          if (w_cnt_zero) begin
            r_cnt <= r_period - DIV_WIDTH'(1);
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
          end
        end
        ST_STOP: begin
          if (w_cnt_zero) begin
            if (w_pop) begin
              r_shift  <= w_head;
              r_period <= w_period;
              r_cnt    <= w_period - DIV_WIDTH'(1);
              r_tx     <= 1'b0;
              r_state  <= ST_START;
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o       = r_tx;
  assign tx_oeb_o   = 1'b0;
  assign busy_o     = (r_state != ST_IDLE) | ~r_empty;
  assign full_o     = r_full;
  assign empty_o    = r_empty;
  assign level_o    = r_level;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_elpis_uart_tx.sv
// tb_elpis_uart_tx - scoreboard bench for elpis_uart_tx.
//
// Stimulus pushes {byte, bit period, contiguous} into exp_q when a write is
// expected to be accepted. A separate UART monitor watches tx_o, pops the
// queue at each start bit and checks the full 10*P-cycle waveform, the
// decoded byte and, where flagged, the absence of an idle gap.

module tb_elpis_uart_tx;

  localparam int FD = 8;
  localparam int DW = 16;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic [DW-1:0] div_i = 16'd4;
  logic          wr_en_i = 1'b0;
  logic [7:0]    wr_data_i = 8'd0;
  logic          clr_ovf_i = 1'b0;
  logic          tx_o;
  logic          tx_oeb_o;
  logic          busy_o;
  logic          full_o;
  logic          empty_o;
  logic [3:0]    level_o;
  logic          overflow_o;

  elpis_uart_tx #(.FIFO_DEPTH(FD), .DIV_WIDTH(DW)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .div_i      (div_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .clr_ovf_i  (clr_ovf_i),
    .tx_o       (tx_o),
    .tx_oeb_o   (tx_oeb_o),
    .busy_o     (busy_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [7:0] data;
    int         period;
    bit         contig;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mon_active = 1'b0;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input int p, input bit acc, input bit contig);
    exp_t e;
    e.data = d;
    e.period = p;
    e.contig = contig;
    wr_en_i = 1'b1;
    wr_data_i = d;
    if (acc) exp_q.push_back(e);
    @(posedge wb_clk_i);
    #1;
    wr_en_i = 1'b0;
  endtask

  // Called right after a write to an idle transmitter: busy must hold for
  // the whole 10*P-cycle frame and drop on the following edge.
  task automatic check_busy_window(input int p);
    repeat (10 * p) @(posedge wb_clk_i);
    #1;
    chk("busy_in_frame", {31'd0, busy_o}, 32'd1);
    @(posedge wb_clk_i);
    #1;
    chk("busy_drop", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((busy_o || mon_active || exp_q.size() != 0) && n < budget) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // UART monitor / scoreboard consumer
  exp_t       m_e;
  int         m_last_end = -100;
  int         m_start;
  int         m_mism;
  int         m_b;
  bit         m_abort;
  logic       m_bit;
  logic [7:0] m_dec;

  initial begin : monitor
    forever begin
      @(negedge wb_clk_i);
      if (!wb_rst_i && tx_o === 1'b0) begin
        mon_active = 1'b1;
        m_start = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          if (m_e.contig) chk("frame_gap", m_start - m_last_end, 32'd1);
          m_mism = 0;
          m_abort = 1'b0;
          m_dec = 8'd0;
          for (int s = 0; s < 10 * m_e.period; s++) begin
            if (s > 0) @(negedge wb_clk_i);
            if (wb_rst_i) begin
              m_abort = 1'b1;
              break;
            end
            m_b = s / m_e.period;
            if (m_b == 0) m_bit = 1'b0;
            else if (m_b == 9) m_bit = 1'b1;
            else m_bit = m_e.data[m_b-1];
            if (tx_o !== m_bit) m_mism++;
            if (m_b >= 1 && m_b <= 8 && (s % m_e.period) == m_e.period / 2)
              m_dec[m_b-1] = tx_o;
          end
          if (!m_abort) begin
            chk("frame_data", {24'd0, m_dec}, {24'd0, m_e.data});
            chk("frame_wave_mismatches", m_mism, 32'd0);
            m_last_end = cyc;
          end else begin
            m_last_end = -100;
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time 400000");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] t3 [10];

  initial begin : stim
    t3 = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h7E, 8'hE7};

    // Reset values
    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rst_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_oeb", {31'd0, tx_oeb_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_full", {31'd0, full_o}, 32'd0);
    chk("rst_empty", {31'd0, empty_o}, 32'd1);
    chk("rst_level", {28'd0, level_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);

    // Single 0x55 at div 4
    @(posedge wb_clk_i);
    #1;
    div_i = 16'd4;
    push_byte(8'h55, 4, 1'b1, 1'b0);
    chk("t1_level", {28'd0, level_o}, 32'd1);
    chk("t1_empty", {31'd0, empty_o}, 32'd0);
    check_busy_window(4);
    wait_idle(200, "t1_idle");

    // "Hi\n" back to back at div 3
    div_i = 16'd3;
    push_byte(8'h48, 3, 1'b1, 1'b0);
    push_byte(8'h69, 3, 1'b1, 1'b1);
    push_byte(8'h0A, 3, 1'b1, 1'b1);
    chk("t2_level", {28'd0, level_o}, 32'd2);
    wait_idle(300, "t2_idle");
    chk("t2_empty", {31'd0, empty_o}, 32'd1);

    // Overflow: 10 writes into an 8-deep FIFO, first byte popped at once
    div_i = 16'd16;
    for (int i = 0; i < 10; i++) push_byte(t3[i], 16, (i < 9), (i >= 1 && i < 9));
    chk("t3_full", {31'd0, full_o}, 32'd1);
    chk("t3_level", {28'd0, level_o}, 32'd8);
    chk("t3_ovf_set", {31'd0, overflow_o}, 32'd1);
    clr_ovf_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    clr_ovf_i = 1'b0;
    chk("t3_ovf_clr", {31'd0, overflow_o}, 32'd0);
    clr_ovf_i = 1'b1;
    push_byte(8'h99, 16, 1'b0, 1'b0);
    clr_ovf_i = 1'b0;
    chk("t3_ovf_set_wins", {31'd0, overflow_o}, 32'd1);
    chk("t3_level_after_drop", {28'd0, level_o}, 32'd8);
    clr_ovf_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    clr_ovf_i = 1'b0;
    chk("t3_ovf_clr2", {31'd0, overflow_o}, 32'd0);
    wait_idle(3000, "t3_idle");

    // Reset during data bit 3 of 0xA5 with two bytes queued
    div_i = 16'd4;
    push_byte(8'hA5, 4, 1'b1, 1'b0);
    push_byte(8'h11, 4, 1'b1, 1'b1);
    push_byte(8'h22, 4, 1'b1, 1'b1);
    chk("t4_level", {28'd0, level_o}, 32'd2);
    repeat (16) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b1;
    exp_q.delete();
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    chk("t4_tx", {31'd0, tx_o}, 32'd1);
    chk("t4_level0", {28'd0, level_o}, 32'd0);
    chk("t4_busy", {31'd0, busy_o}, 32'd0);
    chk("t4_empty", {31'd0, empty_o}, 32'd1);
    push_byte(8'h3C, 4, 1'b1, 1'b0);
    wait_idle(200, "t4_idle");

    // Divisor 0 and 1 behave as 2
    div_i = 16'd0;
    push_byte(8'hFF, 2, 1'b1, 1'b0);
    check_busy_window(2);
    wait_idle(100, "t5a_idle");
    div_i = 16'd1;
    push_byte(8'hFF, 2, 1'b1, 1'b0);
    check_busy_window(2);
    wait_idle(100, "t5b_idle");

    // Divisor change mid-frame applies to the next frame only
    div_i = 16'd4;
    push_byte(8'h0F, 4, 1'b1, 1'b0);
    push_byte(8'hF0, 8, 1'b1, 1'b1);
    repeat (10) @(posedge wb_clk_i);
    #1;
    div_i = 16'd8;
    wait_idle(400, "t6_idle");

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
